// File: rtl/jtkiwi_shr_pkg.sv
// Shared definitions for the kiwi shared-RAM arbiter: FSM state encoding
// and requester identifiers.
package jtkiwi_shr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic GNT_MAIN = 1'b0;
   localparam logic GNT_SUB  = 1'b1;

endpackage

// File: rtl/jtkiwi_shr_arb.sv
// Shared 8 kB RAM arbiter between the main CPU and the sub CPU.
// One access is in flight at a time (IDLE grant -> ACC -> DATA); ties are
// resolved round-robin, and the main CPU can lock the sub CPU out.
// Each CPU is held with wait_n low until its own access has completed.
module jtkiwi_shr_arb
   import jtkiwi_shr_pkg::*;
#(
   parameter int AW = 13,
   parameter int DW = 8
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          main_cs,
   input  logic          main_rnw,
   input  logic [AW-1:0] main_addr,
   input  logic [DW-1:0] main_din,
   output logic [DW-1:0] main_dout,
   output logic          main_wait_n,
   input  logic          main_lock,
   input  logic          sub_cs,
   input  logic          sub_rnw,
   input  logic [AW-1:0] sub_addr,
   input  logic [DW-1:0] sub_din,
   output logic [DW-1:0] sub_dout,
   output logic          sub_wait_n,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   state_t          state_r;
   state_t          state_s;
   logic            gnt_r;
   logic            gnt_rnw_r;
   logic            last_grant_r;
   logic            served_main_r;
   logic            served_sub_r;
   logic            busy_r;
   logic            ram_we_r;
   logic [AW-1:0]   ram_addr_r;
   logic [DW-1:0]   ram_din_r;
   logic [DW-1:0]   main_dout_r;
   logic [DW-1:0]   sub_dout_r;

   logic            req_main_s;
   logic            req_sub_s;
   logic            elig_sub_s;
   logic            grant_s;
   logic            winner_s;
   logic            win_rnw_s;
   logic [AW-1:0]   win_addr_s;
   logic [DW-1:0]   win_din_s;

   // Pending requests: a CPU is pending while selected and not yet acknowledged.
   always_comb begin
      req_main_s = main_cs & ~served_main_r;
      req_sub_s  = sub_cs  & ~served_sub_r;
      elig_sub_s = req_sub_s & ~main_lock;
   end

   assign main_wait_n = ~req_main_s;
   assign sub_wait_n  = ~req_sub_s;

   // Next-state and grant decision; a tie goes to whoever was not served last.
   always_comb begin
      state_s  = state_r;
      grant_s  = 1'b0;
      winner_s = GNT_MAIN;
      case (state_r)
         ST_IDLE: begin
            if (req_main_s && elig_sub_s) begin
               grant_s  = 1'b1;
               winner_s = (last_grant_r == GNT_MAIN) ? GNT_SUB : GNT_MAIN;
               state_s  = ST_ACC;
            end else if (req_main_s) begin
               grant_s  = 1'b1;
               winner_s = GNT_MAIN;
               state_s  = ST_ACC;
            end else if (elig_sub_s) begin
               grant_s  = 1'b1;
               winner_s = GNT_SUB;
               state_s  = ST_ACC;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ACC:  state_s = ST_DATA;
         ST_DATA: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Bus fields of the CPU that wins the current grant.
   always_comb begin
      win_rnw_s  = main_rnw;
      win_addr_s = main_addr;
      win_din_s  = main_din;
      if (winner_s == GNT_SUB) begin
         win_rnw_s  = sub_rnw;
         win_addr_s = sub_addr;
         win_din_s  = sub_din;
      end else begin
         win_rnw_s  = main_rnw;
         win_addr_s = main_addr;
         win_din_s  = main_din;
      end
   end

   // FSM state, grant latch and RAM-side bus; the write strobe lasts one clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         gnt_r      <= GNT_MAIN;
         gnt_rnw_r  <= 1'b1;
         ram_we_r   <= 1'b0;
         ram_addr_r <= {AW{1'b0}};
         ram_din_r  <= {DW{1'b0}};
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != ST_IDLE);
         if (grant_s) begin
            gnt_r      <= winner_s;
            gnt_rnw_r  <= win_rnw_s;
            ram_addr_r <= win_addr_s;
            ram_din_r  <= win_din_s;
            ram_we_r   <= ~win_rnw_s;
         end else begin
            ram_we_r   <= 1'b0;
         end
      end
   end

   // Read data capture and round-robin history, both at the end of DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_dout_r  <= {DW{1'b0}};
         sub_dout_r   <= {DW{1'b0}};
         last_grant_r <= GNT_SUB;
      end else if (state_r == ST_DATA) begin
         last_grant_r <= gnt_r;
         if (gnt_rnw_r && (gnt_r == GNT_MAIN)) begin
            main_dout_r <= ram_dout;
         end
         if (gnt_rnw_r && (gnt_r == GNT_SUB)) begin
            sub_dout_r <= ram_dout;
         end
      end
   end

   // Served flags: set when the access completes, cleared once cs is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         served_main_r <= 1'b0;
         served_sub_r  <= 1'b0;
      end else begin
         if (!main_cs) begin
            served_main_r <= 1'b0;
         end else if ((state_r == ST_DATA) && (gnt_r == GNT_MAIN)) begin
            served_main_r <= 1'b1;
         end
         if (!sub_cs) begin
            served_sub_r <= 1'b0;
         end else if ((state_r == ST_DATA) && (gnt_r == GNT_SUB)) begin
            served_sub_r <= 1'b1;
         end
      end
   end

   assign ram_addr  = ram_addr_r;
   assign ram_din   = ram_din_r;
   assign ram_we    = ram_we_r;
   assign main_dout = main_dout_r;
   assign sub_dout  = sub_dout_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Self-checking bench for jtkiwi_shr_arb: directed scenarios plus random
// access rounds, compared against a transaction-level model of the arbiter.
module tb_jtkiwi_shr_arb;

   logic        clk;
   logic        rst;
   logic        main_cs, main_rnw, main_lock;
   logic [12:0] main_addr;
   logic [7:0]  main_din;
   logic [7:0]  main_dout;
   logic        main_wait_n;
   logic        sub_cs, sub_rnw;
   logic [12:0] sub_addr;
   logic [7:0]  sub_din;
   logic [7:0]  sub_dout;
   logic        sub_wait_n;
   logic [12:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout;
   logic        busy;

   jtkiwi_shr_arb #(.AW(13), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr),
      .main_din(main_din), .main_dout(main_dout), .main_wait_n(main_wait_n),
      .main_lock(main_lock),
      .sub_cs(sub_cs), .sub_rnw(sub_rnw), .sub_addr(sub_addr),
      .sub_din(sub_din), .sub_dout(sub_dout), .sub_wait_n(sub_wait_n),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_dout(ram_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM attached to the arbiter, with a write counter.
   logic [7:0] mem [0:8191];
   logic       mem_clr;
   int         wr_cnt;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
         wr_cnt <= 0;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
         wr_cnt <= wr_cnt + 1;
      end
      ram_dout <= mem[ram_addr];
   end

   // Reference model state
   logic [7:0] shadow [0:8191];
   logic       last_gnt;      // 0 = main served last, 1 = sub
   logic [7:0] prev_md, prev_sd;

   int total_cnt = 0;
   int bad_cnt   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One access round from an idle arbiter: main and/or sub raise cs together.
   task automatic run_round(input logic m_en, input logic s_en,
                            input logic m_rnw, input logic s_rnw,
                            input logic [12:0] m_a, input logic [12:0] s_a,
                            input logic [7:0] m_d, input logic [7:0] s_d,
                            input logic scramble);
      int         exp_mw, exp_sw, exp_wr, m_cnt, s_cnt, we_cnt, wr0;
      logic       m_done, s_done, first_main, do_main, we_ok;
      logic [7:0] exp_md, exp_sd;
      // model: ordering by round-robin, waits 3 for the first, 6 for the second
      exp_md = prev_md;
      exp_sd = prev_sd;
      if (m_en && s_en) first_main = (last_gnt == 1'b1);
      else              first_main = m_en;
      exp_mw = (m_en && s_en && !first_main) ? 6 : 3;
      exp_sw = (m_en && s_en && first_main)  ? 6 : 3;
      exp_wr = ((m_en && !m_rnw) ? 1 : 0) + ((s_en && !s_rnw) ? 1 : 0);
      for (int k = 0; k < 2; k++) begin
         do_main = ((k == 0) == first_main);
         if (do_main && m_en) begin
            if (m_rnw) exp_md = shadow[m_a];
            else       shadow[m_a] = m_d;
            last_gnt = 1'b0;
         end else if (!do_main && s_en) begin
            if (s_rnw) exp_sd = shadow[s_a];
            else       shadow[s_a] = s_d;
            last_gnt = 1'b1;
         end
      end
      // stimulus and observation
      m_cnt = 0; s_cnt = 0; we_cnt = 0;
      m_done = !m_en; s_done = !s_en;
      @(posedge clk); #1;
      wr0 = wr_cnt;
      main_cs = m_en; main_rnw = m_rnw; main_addr = m_a; main_din = m_d;
      sub_cs  = s_en; sub_rnw  = s_rnw; sub_addr  = s_a; sub_din  = s_d;
      for (int c = 0; c < 20 && !(m_done && s_done); c++) begin
         @(negedge clk);
         if (ram_we) begin
            we_cnt++;
            we_ok = (m_en && !m_rnw && ram_addr == m_a && ram_din == m_d) ||
                    (s_en && !s_rnw && ram_addr == s_a && ram_din == s_d);
            check_val("we_bus", we_ok, 1);
         end
         if (!m_done) begin
            if (!main_wait_n) m_cnt++;
            else begin
               m_done = 1'b1;
               check_val("main_wait", m_cnt, exp_mw);
               check_val("main_dout", main_dout, exp_md);
            end
         end
         if (!s_done) begin
            if (!sub_wait_n) s_cnt++;
            else begin
               s_done = 1'b1;
               check_val("sub_wait", s_cnt, exp_sw);
               check_val("sub_dout", sub_dout, exp_sd);
            end
         end
         if (scramble && c == 1) begin
            main_addr = 13'($urandom); main_din = 8'($urandom); main_rnw = 1'($urandom);
            sub_addr  = 13'($urandom); sub_din  = 8'($urandom); sub_rnw  = 1'($urandom);
         end
      end
      if (!(m_done && s_done)) check_val("round_timeout", 0, 1);
      check_val("we_pulses", we_cnt, exp_wr);
      check_val("round_busy", busy, 0);
      @(posedge clk); #1;
      main_cs = 1'b0; sub_cs = 1'b0;
      @(posedge clk); #1;
      check_val("ram_writes", wr_cnt - wr0, exp_wr);
      if (m_en && !m_rnw) check_val("mem_main", mem[m_a], shadow[m_a]);
      if (s_en && !s_rnw) check_val("mem_sub",  mem[s_a], shadow[s_a]);
      prev_md = exp_md;
      prev_sd = exp_sd;
   endtask

   function automatic logic [12:0] rnd_addr();
      logic [12:0] a;
      case ($urandom_range(0, 5))
         0:       a = 13'h0000;
         1:       a = 13'h1FFF;
         default: a = 13'h0100 + 13'($urandom_range(0, 15));
      endcase
      return a;
   endfunction

   initial begin
      int cnt_m, cnt_s, wr0, pat;
      logic ok;
      clk = 1'b0; rst = 1'b1; mem_clr = 1'b1;
      main_cs = 1'b0; main_rnw = 1'b1; main_addr = 13'h0; main_din = 8'h0; main_lock = 1'b0;
      sub_cs  = 1'b0; sub_rnw  = 1'b1; sub_addr  = 13'h0; sub_din  = 8'h0;
      for (int i = 0; i < 8192; i++) shadow[i] = 8'h00;
      last_gnt = 1'b1; prev_md = 8'h00; prev_sd = 8'h00;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_main_wait_n", main_wait_n, 1);
      check_val("rst_sub_wait_n", sub_wait_n, 1);
      @(posedge clk); #1;
      rst = 1'b0; mem_clr = 1'b0;
      @(negedge clk);
      check_val("rst_ram_we", ram_we, 0);
      check_val("rst_main_dout", main_dout, 0);
      check_val("rst_sub_dout", sub_dout, 0);
      check_val("rst_busy", busy, 0);

      // simultaneous requests after reset, then write/read, then tie again
      run_round(1, 1, 1, 1, 13'h0010, 13'h0020, 8'h00, 8'h00, 0);
      run_round(1, 0, 0, 1, 13'h0123, 13'h0000, 8'h5A, 8'h00, 0);
      run_round(1, 0, 1, 1, 13'h0123, 13'h0000, 8'h00, 8'h00, 1);
      run_round(1, 1, 0, 1, 13'h0200, 13'h0123, 8'h77, 8'h00, 0);
      run_round(1, 0, 0, 1, 13'h1FFF, 13'h0000, 8'hA5, 8'h00, 0);

      // lock holds a pending sub read off the RAM
      @(posedge clk); #1;
      main_lock = 1'b1; sub_cs = 1'b1; sub_rnw = 1'b1; sub_addr = 13'h0123;
      ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (sub_wait_n !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      check_val("lock_hold", ok, 1);
      @(posedge clk); #1;
      main_lock = 1'b0;
      cnt_s = 0;
      for (int c = 0; c < 10 && sub_wait_n == 1'b0; c++) begin
         @(negedge clk);
         if (!sub_wait_n) cnt_s++;
      end
      check_val("lock_release", cnt_s, 3);
      check_val("lock_sub_dout", sub_dout, shadow[13'h0123]);
      prev_sd = shadow[13'h0123]; last_gnt = 1'b1;
      @(posedge clk); #1; sub_cs = 1'b0;
      @(posedge clk); #1;

      // lock raised while a sub read is in ACC: sub finishes, then main
      sub_cs = 1'b1; sub_rnw = 1'b1; sub_addr = 13'h1FFF;
      @(posedge clk); #1;
      main_lock = 1'b1; main_cs = 1'b1; main_rnw = 1'b1; main_addr = 13'h0123;
      cnt_m = 0; cnt_s = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (!main_wait_n) cnt_m++;
         if (!sub_wait_n)  cnt_s++;
      end
      check_val("inflight_sub_wait", cnt_s, 2);
      check_val("inflight_main_wait", cnt_m, 5);
      check_val("inflight_sub_dout", sub_dout, shadow[13'h1FFF]);
      check_val("inflight_main_dout", main_dout, shadow[13'h0123]);
      prev_sd = shadow[13'h1FFF]; prev_md = shadow[13'h0123]; last_gnt = 1'b0;
      main_cs = 1'b0; sub_cs = 1'b0; main_lock = 1'b0;
      @(posedge clk); #1;

      // reset during the ACC state of a main write
      wr0 = wr_cnt;
      main_cs = 1'b1; main_rnw = 1'b0; main_addr = 13'h0456; main_din = 8'hC3;
      @(posedge clk); #1;
      rst = 1'b1; main_cs = 1'b0;
      @(negedge clk);
      check_val("rst_acc_we_before", ram_we, 1);
      @(negedge clk);
      check_val("rst_acc_we", ram_we, 0);
      check_val("rst_acc_busy", busy, 0);
      check_val("rst_acc_wait_n", main_wait_n, 1);
      check_val("rst_acc_dout", {main_dout, sub_dout}, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("rst_acc_writes", wr_cnt - wr0, 1);
      check_val("rst_acc_mem", mem[13'h0456], 8'hC3);
      shadow[13'h0456] = 8'hC3; prev_md = 8'h00; prev_sd = 8'h00; last_gnt = 1'b1;

      // random rounds
      for (int r = 0; r < 40; r++) begin
         pat = $urandom_range(1, 3);
         run_round(pat[0], pat[1], 1'($urandom), 1'($urandom), rnd_addr(), rnd_addr(),
                   8'($urandom), 8'($urandom), (pat != 3) && ($urandom_range(0, 1) == 1));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/jtkiwi_shr_arb.md
Name: jtkiwi_shr_arb

Overview:
- Arbitrates the single-port 8 kB shared RAM between the main CPU and the sub (sound/I/O) CPU.
- Sits between the two CPU buses and the dual-use RAM block in the kiwi core, clocked at the 24 MHz CPU clock.
- Serialises accesses with a round-robin grant.
- Stretches the losing CPU with an active-low wait signal until its access has completed.
- Honours a main-CPU lock that holds the sub CPU off the RAM.

Parameters:
AW, 13, address width of the shared RAM (8 kB)
DW, 8, data width

Ports:
clk  in  1  CPU clock (24 MHz)
rst  in  1  synchronous reset, active high
main_cs  in  1  main CPU selects shared RAM, held for the whole bus cycle
main_rnw  in  1  main CPU read (1) / write (0)
main_addr  in  AW  main CPU address
main_din  in  DW  main CPU write data
main_dout  out  DW  read data returned to main CPU (registered)
main_wait_n  out  1  low while a main access is pending
main_lock  in  1  main CPU owns RAM exclusively; sub requests are not granted
sub_cs  in  1  sub CPU selects shared RAM
sub_rnw  in  1  sub CPU read/write
sub_addr  in  AW  sub CPU address
sub_din  in  DW  sub CPU write data
sub_dout  out  DW  read data returned to sub CPU (registered)
sub_wait_n  out  1  low while a sub access is pending
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
ram_we  out  1  RAM write strobe, one clk
ram_dout  in  DW  RAM read data, valid one clk after address
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset values (synchronous, active high):
  - state = IDLE
  - main_dout = sub_dout = 0; ram_addr = 0; ram_din = 0; ram_we = 0
  - served_main = served_sub = 0; last_grant = SUB, so main wins the first tie
  - busy = 0
- Pending and wait:
  - req_x = x_cs & ~served_x
  - x_wait_n = ~req_x, combinational; it is high whenever cs is low, including during reset.
  - served_x clears on the first clk where x_cs = 0. The CPU must drop cs between accesses; a continuously held cs counts as one access.
- FSM states: IDLE, ACC, DATA.
  - IDLE:
    - Eligible requesters are req_main, and req_sub & ~main_lock.
    - If both are eligible, grant the one that is not last_grant.
    - On a grant: latch gnt, drive ram_addr/ram_din from the winner, and set ram_we = ~winner_rnw for exactly the next clk. Go to ACC.
  - ACC:
    - ram_we returns to 0.
    - Address is held; RAM read is in flight. Go to DATA.
  - DATA:
    - If gnt was a read, capture ram_dout into gnt_dout; on a write, gnt_dout is unchanged.
    - Set served_gnt = 1 and last_grant = gnt. Go to IDLE.
    - The winner's wait_n rises in the clk after DATA.
- Latency: an uncontended access takes wait_n low for 3 clks (IDLE grant, ACC, DATA).
- Worst case for the loser under contention, without lock: 6 clks.
- main_lock:
  - Sampled only in IDLE. Asserting it mid-access does not abort a sub access in flight.
  - While lock = 1, sub_wait_n stays low indefinitely as long as sub_cs is held.
- A cs that drops mid-access (ACC/DATA): the access still completes to RAM. The served flag is then cleared on the next clk with cs low, so no stale ack carries over.
- Address/data/rnw are sampled only at grant; later changes are ignored.
- Reset mid-operation: FSM returns to IDLE, ram_we is forced 0 the same clk, served flags clear, and no partial write is repeated.

Decomposition:
- A small package, jtkiwi_shr_pkg, holds:
  - the state encoding (IDLE=0, ACC=1, DATA=2)
  - the requester id constants (GNT_MAIN=0, GNT_SUB=1)
- No sub-module; the FSM plus two served flags form a single module.

Test Plan:
- Reset, both cs low -> both wait_n = 1, ram_we = 0, main_dout = sub_dout = 0, busy = 0.
- Main write 0x5A to 0x0123, then main read of 0x0123 after dropping cs -> ram_we high for exactly 1 clk with ram_addr = 0x0123; read returns main_dout = 0x5A; main_wait_n low for 3 clks per access.
- main_cs and sub_cs rise on the same clk after reset -> main granted first. sub_wait_n stays low 6 clks. On the next simultaneous request pair, sub is granted first (round-robin).
- main_lock = 1 with sub read pending for 20 clks -> sub_wait_n stays 0, no RAM access for sub. Lock drops -> sub served within 3 clks.
- Sub read in flight (ACC), then main_lock rises -> sub access completes with sub_dout = RAM content; main is granted next.
- rst pulsed during a write's ACC state -> ram_we = 0 the same clk; state IDLE, served flags cleared, RAM written only once.
